inta_bus_sequencer: RTL and testbench

- CPU-side bus engine directly downstream of the 8259 top; consumes INT_Flag and drives the PIC's INTA, read_flag, write_flag, chip_select, A0 and data_Bus pins.
- Runs the two-pulse interrupt-acknowledge cycle, captures the vector byte, and presents it to the core with a valid/ack handshake.
- Issues the OCW2 end-of-interrupt write on request. It replaces hand-sequenced pin toggling in system-level benches and the SoC wrapper.

---
 rtl/pic_bus_pkg.sv | 31 +++
 rtl/pic_sync_ff.sv | 24 ++
 rtl/inta_bus_sequencer.sv | 166 ++++++++++++++++
 tb/tb_inta_bus_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the CPU-side 8259 bus blocks.
// Holds the sequencer state encoding, OCW2 command bytes and default timing.
package pic_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK1_LO,
        ACK1_GAP,
        ACK2_LO,
        VEC_HOLD,
        EOI_SETUP,
        EOI_LO,
        EOI_GAP
    } bus_state_e;

    localparam logic [7:0] EOI_NONSPEC   = 8'h20;
    localparam logic [7:0] EOI_SPEC_BASE = 8'h60;

    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam int DEF_PULSE_W     = 2;
    localparam int DEF_GAP_W       = 2;
    localparam int DEF_SYNC_STAGES = 2;

    // OCW2 end-of-interrupt byte: specific EOI carries the IR level in bits [2:0].
    function automatic logic [7:0] eoi_cmd_byte(input logic specific, input logic [2:0] level);
        return specific ? (EOI_SPEC_BASE | {5'b00000, level}) : EOI_NONSPEC;
    endfunction

endpackage

// File: rtl/pic_sync_ff.sv
// Multi-flop synchronizer for asynchronous PIC-side level signals.
// Clears to 0 on asynchronous active-low reset.
module pic_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/inta_bus_sequencer.sv
// CPU-side bus engine for the 8259: runs the two-pulse INTA cycle, captures the
// vector for the core, and issues OCW2 end-of-interrupt writes on request.
module inta_bus_sequencer
    import pic_bus_pkg::*;
#(
    parameter int PULSE_W     = DEF_PULSE_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_flag,
    output logic       inta,
    output logic       read_flag,
    output logic       write_flag,
    output logic       chip_select,
    output logic       a0,
    inout  wire  [7:0] data_bus,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ack,
    input  logic       eoi_req,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       busy,
    output bus_state_e state_dbg
);

    // Core handshake: vector_valid stays high from capture until the first cycle
    // vector_ack is seen in VEC_HOLD; vector_ack at any other time is ignored.

    localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] PULSE_RLD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_RLD   = CW'(GAP_W - 1);

    bus_state_e    state;
    logic [CW-1:0] cnt;
    logic          int_sync;
    logic          eoi_pend;
    logic [7:0]    eoi_cmd;
    logic          data_oe;
    logic [7:0]    data_out;

    pic_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (int_flag),
        .q    (int_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            inta         <= 1'b1;
            write_flag   <= 1'b1;
            chip_select  <= 1'b1;
            a0           <= A0_DATA;
            data_oe      <= 1'b0;
            data_out     <= '0;
            vector       <= '0;
            vector_valid <= 1'b0;
            eoi_pend     <= 1'b0;
            eoi_cmd      <= '0;
        end else begin
            // Requests are latched with their command byte so they survive a busy bus.
            if (eoi_req && !eoi_pend) begin
                eoi_pend <= 1'b1;
                eoi_cmd  <= eoi_cmd_byte(eoi_specific, eoi_level);
            end

            case (state)
                IDLE: begin
                    if (eoi_pend) begin
                        state       <= EOI_SETUP;
                        cnt         <= '0;
                        chip_select <= 1'b0;
                        a0          <= A0_CMD;
                        data_oe     <= 1'b1;
                        data_out    <= eoi_cmd;
                    end else if (int_sync) begin
                        state <= ACK1_LO;
                        cnt   <= PULSE_RLD;
                        inta  <= 1'b0;
                    end
                end
                ACK1_LO: begin
                    if (cnt == '0) begin
                        state <= ACK1_GAP;
                        cnt   <= GAP_RLD;
                        inta  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK1_GAP: begin
                    if (cnt == '0) begin
                        state <= ACK2_LO;
                        cnt   <= PULSE_RLD;
                        inta  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK2_LO: begin
                    if (cnt == '0) begin
                        state        <= VEC_HOLD;
                        cnt          <= '0;
                        inta         <= 1'b1;
                        vector       <= data_bus;
                        vector_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                VEC_HOLD: begin
                    if (vector_ack) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        vector_valid <= 1'b0;
                    end
                end
                EOI_SETUP: begin
                    state      <= EOI_LO;
                    cnt        <= PULSE_RLD;
                    write_flag <= 1'b0;
                end
                EOI_LO: begin
                    if (cnt == '0) begin
                        state      <= EOI_GAP;
                        cnt        <= GAP_RLD;
                        write_flag <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EOI_GAP: begin
                    // Data, select and A0 stay valid through the first gap cycle for hold time.
                    chip_select <= 1'b1;
                    a0          <= A0_DATA;
                    data_oe     <= 1'b0;
                    if (cnt == '0) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        eoi_pend <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign data_bus  = data_oe ? data_out : 8'hzz;
    assign read_flag = 1'b1;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_inta_bus_sequencer.sv
// Bench for inta_bus_sequencer: a behavioural PIC on the data bus, a transaction
// scoreboard, a vector table, hand-written corner sequences and random traffic.
module tb_inta_bus_sequencer;
    import pic_bus_pkg::*;

    localparam int PULSE_W = 2;
    localparam int GAP_W   = 2;
    localparam int SYNC_ST = 2;
    localparam int LATENCY = SYNC_ST + 1 + 2 * PULSE_W + GAP_W;

    logic       clk;
    logic       rst_n;
    logic       int_flag;
    logic       inta;
    logic       read_flag;
    logic       write_flag;
    logic       chip_select;
    logic       a0;
    wire  [7:0] data_bus;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ack;
    logic       eoi_req;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       busy;
    bus_state_e state_dbg;

    inta_bus_sequencer #(
        .PULSE_W    (PULSE_W),
        .GAP_W      (GAP_W),
        .SYNC_STAGES(SYNC_ST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .int_flag    (int_flag),
        .inta        (inta),
        .read_flag   (read_flag),
        .write_flag  (write_flag),
        .chip_select (chip_select),
        .a0          (a0),
        .data_bus    (data_bus),
        .vector      (vector),
        .vector_valid(vector_valid),
        .vector_ack  (vector_ack),
        .eoi_req     (eoi_req),
        .eoi_specific(eoi_specific),
        .eoi_level   (eoi_level),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- PIC model: junk on first INTA pulse, vector on second ----------------
    logic [7:0] pic_vec;
    int         inta_falls;
    always @(negedge inta or negedge rst_n) begin
        if (!rst_n) inta_falls <= 0;
        else        inta_falls <= inta_falls + 1;
    end
    assign data_bus = (inta == 1'b0) ? ((inta_falls % 2 == 1) ? 8'hFF : pic_vec) : 8'hzz;

    // ---------------- bus monitor ----------------
    logic [8:0] obs_q[$];
    int         inta_run, wr_run, wr_count;
    int         viol_overlap, viol_cs, viol_width;
    logic [7:0] wr_byte;
    logic       prev_valid;

    initial begin
        viol_overlap = 0; viol_cs = 0; viol_width = 0; wr_count = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            inta_run   = 0;
            wr_run     = 0;
            prev_valid = 1'b0;
        end else begin
            if (inta == 1'b0 && write_flag == 1'b0) viol_overlap++;
            if (chip_select == 1'b0 && inta == 1'b0) viol_cs++;
            if (inta == 1'b0) inta_run++;
            else begin
                if (inta_run != 0 && inta_run != PULSE_W) viol_width++;
                inta_run = 0;
            end
            if (write_flag == 1'b0) begin
                wr_run++;
                wr_byte = data_bus;
                if (chip_select != 1'b0 || a0 != 1'b0) viol_cs++;
            end else if (wr_run != 0) begin
                if (wr_run != PULSE_W) viol_width++;
                wr_run = 0;
                wr_count++;
                obs_q.push_back({1'b1, wr_byte});
            end
            if (vector_valid && !prev_valid) obs_q.push_back({1'b0, vector});
            prev_valid = vector_valid;
        end
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int         checks, failures;
    logic [7:0] last_obs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: OCW2 EOI byte from the command rules, plain arithmetic.
    function automatic logic [7:0] ref_eoi_byte(input bit spec, input int lvl);
        return spec ? 8'(96 + lvl) : 8'(32);
    endfunction

    task automatic drain();
        logic [8:0] o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            last_obs = o[7:0];
            if (exp_q.size() == 0) check("sb_unexpected", 32'(o), 32'h1ff);
            else check("sb_txn", 32'(o), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_inta(input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inta == lvl) return;
            tick(1);
        end
        check("timeout_inta", 32'(inta), 32'(lvl));
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (vector_valid) return;
            tick(1);
        end
        check("timeout_valid", 32'(vector_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) quiet++; else quiet = 0;
            if (quiet >= 4) return;
            tick(1);
        end
        check("timeout_idle", 32'(busy), 32'd0);
    endtask

    task automatic ack_vector(input int delay);
        tick(delay);
        vector_ack = 1'b1;
        tick(1);
        vector_ack = 1'b0;
    endtask

    task automatic run_int(input logic [7:0] vec, input logic [7:0] exp_byte, input int ack_dly,
                           input bit eoi_in_hold, input bit eoi_spec, input logic [2:0] eoi_lvl);
        pic_vec = vec;
        exp_q.push_back({1'b0, exp_byte});
        int_flag = 1'b1;
        wait_inta(1'b0, 40);
        int_flag = 1'b0;
        wait_valid(40);
        if (eoi_in_hold) begin
            eoi_specific = eoi_spec;
            eoi_level    = eoi_lvl;
            eoi_req      = 1'b1;
            exp_q.push_back({1'b1, ref_eoi_byte(eoi_spec, int'(eoi_lvl))});
            tick(1);
            eoi_req = 1'b0;
        end
        ack_vector(ack_dly);
        wait_idle(60);
        drain();
    endtask

    task automatic run_eoi(input bit spec, input logic [2:0] lvl, input logic [7:0] exp_byte);
        eoi_specific = spec;
        eoi_level    = lvl;
        eoi_req      = 1'b1;
        exp_q.push_back({1'b1, exp_byte});
        tick(1);
        eoi_req = 1'b0;
        wait_idle(60);
        drain();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         is_eoi;
        bit         spec;
        logic [2:0] lvl;
        logic [7:0] vec;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int f0;
        checks = 0; failures = 0;
        rst_n = 1'b0; int_flag = 1'b0; vector_ack = 1'b0;
        eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; pic_vec = 8'h00;

        tbl[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h20};
        tbl[1] = '{1'b1, 1'b1, 3'd4, 8'h00, 8'h64};
        tbl[2] = '{1'b1, 1'b1, 3'd7, 8'h00, 8'h67};
        tbl[3] = '{1'b1, 1'b1, 3'd0, 8'h00, 8'h60};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 8'hA5, 8'hA5};
        tbl[5] = '{1'b0, 1'b0, 3'd0, 8'h3C, 8'h3C};

        // Reset values
        tick(2);
        check("rst_inta", 32'(inta), 32'd1);
        check("rst_read", 32'(read_flag), 32'd1);
        check("rst_write", 32'(write_flag), 32'd1);
        check("rst_cs", 32'(chip_select), 32'd1);
        check("rst_a0", 32'(a0), 32'd1);
        check("rst_vector", 32'(vector), 32'h00);
        check("rst_valid", 32'(vector_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        tick(2);

        // Basic ack with latency, hold while int_flag stays high, then ack
        pic_vec = 8'h08;
        exp_q.push_back({1'b0, 8'h08});
        int_flag = 1'b1;
        for (int k = 1; k <= LATENCY; k++) begin
            tick(1);
            if (k == LATENCY - 1) check("lat_not_yet", 32'(vector_valid), 32'd0);
        end
        check("lat_valid", 32'(vector_valid), 32'd1);
        check("basic_vector", 32'(vector), 32'h08);
        check("basic_pulses", 32'(inta_falls), 32'd2);
        tick(6);
        check("hold_no_pulse", 32'(inta_falls), 32'd2);
        check("hold_valid", 32'(vector_valid), 32'd1);
        int_flag = 1'b0;
        ack_vector(3);
        check("ack_clears", 32'(vector_valid), 32'd0);
        check("ack_keeps_vec", 32'(vector), 32'h08);
        tick(4);
        check("post_ack_idle", 32'(busy), 32'd0);
        drain();

        // Ack outside VEC_HOLD is ignored
        vector_ack = 1'b1;
        tick(1);
        vector_ack = 1'b0;
        tick(1);
        check("stray_ack_valid", 32'(vector_valid), 32'd0);
        check("stray_ack_busy", 32'(busy), 32'd0);

        // Table-driven EOI and INTA transactions
        foreach (tbl[i]) begin
            if (tbl[i].is_eoi) run_eoi(tbl[i].spec, tbl[i].lvl, tbl[i].exp_byte);
            else run_int(tbl[i].vec, tbl[i].exp_byte, 1, 1'b0, 1'b0, 3'd0);
            check($sformatf("tbl%0d", i), 32'(last_obs), 32'(tbl[i].exp_byte));
        end

        // int_flag drops during ACK1_GAP: second pulse still issued
        pic_vec = 8'hC3;
        exp_q.push_back({1'b0, 8'hC3});
        int_flag = 1'b1;
        wait_inta(1'b0, 40);
        wait_inta(1'b1, 10);
        int_flag = 1'b0;
        wait_valid(20);
        check("gapdrop_vector", 32'(vector), 32'hC3);
        ack_vector(2);
        wait_idle(40);
        drain();

        // Collision: EOI and INT in the same IDLE window; EOI goes first
        pic_vec = 8'h5A;
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h5A});
        eoi_specific = 1'b0;
        eoi_req = 1'b1;
        int_flag = 1'b1;
        tick(1);
        eoi_req = 1'b0;
        wait_valid(60);
        int_flag = 1'b0;
        ack_vector(3);
        wait_idle(40);
        drain();
        check("collision_order_done", 32'(exp_q.size()), 32'd0);

        // Second request while one is pending is dropped
        f0 = wr_count;
        eoi_specific = 1'b0;
        eoi_req = 1'b1;
        exp_q.push_back({1'b1, 8'h20});
        tick(1);
        eoi_specific = 1'b1;
        eoi_level = 3'd5;
        tick(1);
        eoi_req = 1'b0;
        wait_idle(60);
        drain();
        check("dup_eoi_writes", 32'(wr_count - f0), 32'd1);

        // Reset in the middle of ACK1_LO aborts immediately
        pic_vec = 8'h77;
        int_flag = 1'b1;
        wait_inta(1'b0, 40);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_inta", 32'(inta), 32'd1);
        check("midrst_cs", 32'(chip_select), 32'd1);
        check("midrst_vector", 32'(vector), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        int_flag = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        check("midrst_inta_after", 32'(inta), 32'd1);

        // Random traffic against the scoreboard
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                bit sp = 1'($urandom_range(0, 1));
                int lv = $urandom_range(0, 7);
                run_eoi(sp, 3'(lv), ref_eoi_byte(sp, lv));
            end else begin
                logic [7:0] v = 8'($urandom_range(0, 255));
                bit hold_eoi  = ($urandom_range(0, 2) == 0);
                bit sp        = 1'($urandom_range(0, 1));
                int lv        = $urandom_range(0, 7);
                run_int(v, v, $urandom_range(0, 4), hold_eoi, sp, 3'(lv));
            end
        end

        // Protocol invariants over the whole run
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("no_strobe_overlap", 32'(viol_overlap), 32'd0);
        check("cs_a0_protocol", 32'(viol_cs), 32'd0);
        check("strobe_widths", 32'(viol_width), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
